// File: rtl/nn_neuron_sequencer_if.sv
// Bundle between the neuron sequencer and its layer buffers, its MAC and the
// downstream activation consumer.
interface nn_neuron_sequencer_if #(
  parameter int XAW = 3,
  parameter int WAW = 5,
  parameter int BAW = 2
);
  logic        [XAW-1:0] x_addr;
  logic signed [15:0]    x_rd_data;
  logic        [WAW-1:0] w_addr;
  logic signed [15:0]    w_rd_data;
  logic        [BAW-1:0] b_addr;
  logic signed [31:0]    b_rd_data;
  logic        [3:0]     mac_ctrl;
  logic signed [15:0]    mac_in;
  logic signed [15:0]    mac_w;
  logic signed [31:0]    mac_bias;
  logic signed [15:0]    mac_zout;
  logic signed [15:0]    y_data;
  logic        [BAW-1:0] y_idx;
  logic                  y_valid;
  logic                  y_ready;

  modport master (
    output x_addr, w_addr, b_addr, mac_ctrl, mac_in, mac_w, mac_bias,
           y_data, y_idx, y_valid,
    input  x_rd_data, w_rd_data, b_rd_data, mac_zout, y_ready
  );
  modport slave (
    input  x_addr, w_addr, b_addr, mac_ctrl, mac_in, mac_w, mac_bias,
           y_data, y_idx, y_valid,
    output x_rd_data, w_rd_data, b_rd_data, mac_zout, y_ready
  );
endinterface

// File: rtl/nn_neuron_sequencer.sv
// Sequences one time-multiplexed MAC through a layer of N_OUT neurons and
// streams one (optionally ReLU-clamped) activation per neuron.
module nn_neuron_sequencer #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 4,
  parameter int RELU  = 1,
  parameter int XAW   = 3,
  parameter int WAW   = 5,
  parameter int BAW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  nn_neuron_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD_B, CLEAR, MAC, WAIT, OUT, DONE} state_t;

  state_t             state, state_nx;
  logic [BAW-1:0]     j, j_nx;
  logic [XAW-1:0]     k, k_nx;
  logic signed [15:0] y_data_nx;
  logic [BAW-1:0]     y_idx_nx;
  logic               y_valid_nx;
  logic [WAW-1:0]     w_base;

  assign w_base = WAW'(j) * WAW'(N_IN);
  assign busy   = (state != IDLE) && (state != DONE);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      j           <= '0;
      k           <= '0;
      bus.y_data  <= '0;
      bus.y_idx   <= '0;
      bus.y_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      j           <= j_nx;
      k           <= k_nx;
      bus.y_data  <= y_data_nx;
      bus.y_idx   <= y_idx_nx;
      bus.y_valid <= y_valid_nx;
    end
  end

  // Memory reads have one cycle of latency: addresses issued in CLEAR and in
  // each MAC cycle return the operand consumed by the following MAC cycle.
  always_comb begin
    state_nx     = state;
    j_nx         = j;
    k_nx         = k;
    y_data_nx    = bus.y_data;
    y_idx_nx     = bus.y_idx;
    y_valid_nx   = bus.y_valid;
    bus.x_addr   = '0;
    bus.w_addr   = '0;
    bus.b_addr   = j;
    bus.mac_ctrl = 4'b0000;
    bus.mac_in   = '0;
    bus.mac_w    = '0;
    bus.mac_bias = '0;
    case (state)
      IDLE: if (start) begin
        state_nx = LOAD_B;
        j_nx     = '0;
      end
      LOAD_B: state_nx = CLEAR;
      CLEAR: begin
        bus.mac_ctrl = 4'b1111;
        bus.mac_bias = bus.b_rd_data;
        bus.w_addr   = w_base;
        k_nx         = '0;
        state_nx     = MAC;
      end
      MAC: begin
        bus.mac_in = bus.x_rd_data;
        bus.mac_w  = bus.w_rd_data;
        bus.x_addr = k + XAW'(1);
        bus.w_addr = w_base + WAW'(k) + WAW'(1);
        if (k == XAW'(N_IN - 1)) state_nx = WAIT;
        else                     k_nx     = k + XAW'(1);
      end
      WAIT: begin
        // Q6.10 window is taken as-is; overflow is the MAC's truncation.
        if (RELU != 0 && bus.mac_zout[15]) y_data_nx = '0;
        else                               y_data_nx = bus.mac_zout;
        y_idx_nx   = j;
        y_valid_nx = 1'b1;
        state_nx   = OUT;
      end
      OUT: if (bus.y_ready) begin
        y_valid_nx = 1'b0;
        if (j == BAW'(N_OUT - 1)) begin
          state_nx = DONE;
          j_nx     = '0;
        end else begin
          j_nx     = j + BAW'(1);
          state_nx = LOAD_B;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_nn_neuron_sequencer.sv
// Runs a RELU=1 and a RELU=0 sequencer side by side against shared layer
// memories and a behavioural MAC; results come from a sum-of-products model.
module tb_nn_neuron_sequencer;
  localparam int N_IN = 4, N_OUT = 2, XAW = 2, WAW = 3, BAW = 1;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, y_ready = 1'b1;
  logic busy1, done1, busy0, done0;
  int   checks = 0, failures = 0;
  int   ndone, busy_after;

  logic signed [15:0] xm [N_IN];
  logic signed [15:0] wm [N_IN*N_OUT];
  logic signed [31:0] bm [N_OUT];
  logic signed [31:0] acc1 = 0, acc0 = 0;
  logic [31:0] got1 [$];
  logic [31:0] got0 [$];

  always #5 clk = ~clk;

  nn_neuron_sequencer_if #(.XAW(XAW), .WAW(WAW), .BAW(BAW)) b1 ();
  nn_neuron_sequencer_if #(.XAW(XAW), .WAW(WAW), .BAW(BAW)) b0 ();

  nn_neuron_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .RELU(1), .XAW(XAW), .WAW(WAW), .BAW(BAW))
    u_relu (.clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1), .bus(b1));
  nn_neuron_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .RELU(0), .XAW(XAW), .WAW(WAW), .BAW(BAW))
    u_lin (.clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0), .bus(b0));

  // Synchronous-read memories and a MAC that accumulates whenever ctrl != 4'hF.
  always @(posedge clk) begin
    b1.x_rd_data <= xm[b1.x_addr];
    b1.w_rd_data <= wm[b1.w_addr];
    b1.b_rd_data <= bm[b1.b_addr];
    b0.x_rd_data <= xm[b0.x_addr];
    b0.w_rd_data <= wm[b0.w_addr];
    b0.b_rd_data <= bm[b0.b_addr];
    acc1 <= (b1.mac_ctrl == 4'hF) ? b1.mac_bias : acc1 + 32'(b1.mac_w) * 32'(b1.mac_in);
    acc0 <= (b0.mac_ctrl == 4'hF) ? b0.mac_bias : acc0 + 32'(b0.mac_w) * 32'(b0.mac_in);
  end
  assign b1.mac_zout = acc1[25:10];
  assign b0.mac_zout = acc0[25:10];
  assign b1.y_ready  = y_ready;
  assign b0.y_ready  = y_ready;

  function automatic logic [31:0] exp_entry(int jj, bit relu);
    logic signed [31:0] a;
    logic [15:0] z;
    a = bm[jj];
    for (int kk = 0; kk < N_IN; kk++) a = a + 32'(xm[kk]) * 32'(wm[jj*N_IN+kk]);
    z = a[25:10];
    if (relu && z[15]) z = 16'd0;
    return {16'(jj), z};
  endfunction

  task automatic fill_random();
    int v;
    for (int i = 0; i < N_IN; i++) begin v = int'($urandom_range(0, 8191)) - 4096; xm[i] = 16'(v); end
    for (int i = 0; i < N_IN*N_OUT; i++) begin v = int'($urandom_range(0, 8191)) - 4096; wm[i] = 16'(v); end
    for (int i = 0; i < N_OUT; i++) begin v = int'($urandom_range(0, 1 << 23)) - (1 << 22); bm[i] = 32'(v); end
  endtask

  task automatic fill_basic();
    xm[0] = 16'sd1024; xm[1] = 16'sd2048; xm[2] = -16'sd1024; xm[3] = 16'sd512;
    for (int i = 0; i < N_IN; i++) begin wm[i] = 16'sd1024; wm[N_IN+i] = -16'sd1024; end
    bm[0] = 0; bm[1] = 0;
  endtask

  // mode 0: ready high; 1: random ready; 2: 3-cycle stall on first output;
  // 3: start pulsed mid-pass and in the done cycle.
  task automatic run_pass(input int mode, output int t_valid, output int t_done);
    int t, tail, stall;
    logic [79:0] cap, obs;
    got1.delete(); got0.delete();
    ndone = 0; busy_after = 0; t_valid = -1; t_done = -1; tail = 0; stall = 0; cap = '0;
    y_ready = (mode == 2) ? 1'b0 : 1'b1;
    start = 1'b1;
    t = -1;
    while (t < 600 && tail < 8) begin
      @(negedge clk);
      t++;
      start = (mode == 3 && t == 3);
      if (mode == 1) y_ready = 1'($urandom_range(0, 1));
      obs = {b1.y_valid, 15'(b1.y_idx), b1.y_data, b1.mac_zout,
             b1.mac_ctrl, b0.mac_ctrl, b1.mac_in | b1.mac_w, b0.mac_in | b0.mac_w};
      if (mode == 2 && stall > 0 && stall <= 3) begin
        checks++;
        if (obs !== cap) begin
          failures++;
          $display("FAIL stall cycle %0d: got %h exp %h", stall, obs, cap);
        end
        stall++;
        if (stall == 4) y_ready = 1'b1;
      end
      if (mode == 2 && stall == 0 && b1.y_valid) begin
        cap = {b1.y_valid, 15'(b1.y_idx), b1.y_data, b1.mac_zout, 4'h0, 4'h0, 16'h0, 16'h0};
        stall = 1;
      end
      if (b1.y_valid && t_valid < 0) t_valid = t;
      if (b1.y_valid && y_ready) got1.push_back({16'(b1.y_idx), b1.y_data});
      if (b0.y_valid && y_ready) got0.push_back({16'(b0.y_idx), b0.y_data});
      if (t_done >= 0 && (busy1 || busy0)) busy_after++;
      if (done1) begin
        ndone++;
        if (t_done < 0) t_done = t;
        if (mode == 3) start = 1'b1;
      end
      if (t_done >= 0) tail++;
    end
    start = 1'b0;
    y_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [93:0] obs1, obs0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs1 = {busy1, done1, b1.y_valid, b1.y_idx, b1.y_data, b1.mac_ctrl, b1.mac_in, b1.mac_w,
            b1.mac_bias, b1.x_addr, b1.w_addr, b1.b_addr};
    obs0 = {busy0, done0, b0.y_valid, b0.y_idx, b0.y_data, b0.mac_ctrl, b0.mac_in, b0.mac_w,
            b0.mac_bias, b0.x_addr, b0.w_addr, b0.b_addr};
    checks++; if (obs1 !== '0) begin failures++; $display("FAIL reset relu outputs: got %h exp 0", obs1); end
    checks++; if (obs0 !== '0) begin failures++; $display("FAIL reset lin outputs: got %h exp 0", obs0); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy1, done1, b1.y_valid} !== 3'b000) begin
      failures++; $display("FAIL idle after reset: got %b exp 000", {busy1, done1, b1.y_valid});
    end
  endtask

  task automatic test_basic();
    int tv, td;
    fill_basic();
    run_pass(0, tv, td);
    checks++; if (tv != 7)  begin failures++; $display("FAIL basic first valid: got %0d exp 7", tv); end
    checks++; if (td != 16) begin failures++; $display("FAIL basic done cycle: got %0d exp 16", td); end
    checks++; if (ndone != 1) begin failures++; $display("FAIL basic done pulses: got %0d exp 1", ndone); end
    checks++;
    if (got1.size() != 2 || got1[0] !== 32'h0000_0A00 || got1[1] !== 32'h0001_0000) begin
      failures++; $display("FAIL basic relu outputs: got %p exp '{00000a00,00010000}", got1);
    end
    checks++;
    if (got0.size() != 2 || got0[0] !== 32'h0000_0A00 || got0[1] !== 32'h0001_F600) begin
      failures++; $display("FAIL basic linear outputs: got %p exp '{00000a00,0001f600}", got0);
    end
  endtask

  task automatic test_bias();
    int tv, td;
    fill_basic();
    bm[1] = 32'sd3145728;
    run_pass(0, tv, td);
    checks++;
    if (got1.size() != 2 || got1[1] !== 32'h0001_0200) begin
      failures++; $display("FAIL bias relu neuron1: got %p exp 00010200 at [1]", got1);
    end
    checks++;
    if (got0.size() != 2 || got0[1] !== 32'h0001_0200) begin
      failures++; $display("FAIL bias linear neuron1: got %p exp 00010200 at [1]", got0);
    end
  endtask

  task automatic test_backpressure();
    int tv, td;
    fill_random();
    run_pass(2, tv, td);
    checks++; if (td != 19) begin failures++; $display("FAIL stall done cycle: got %0d exp 19", td); end
    for (int i = 0; i < N_OUT; i++) begin
      checks++;
      if (got1.size() <= i || got1[i] !== exp_entry(i, 1)) begin
        failures++; $display("FAIL stall out%0d: got %p exp %h", i, got1, exp_entry(i, 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    int tv, td;
    logic [63:0] obs;
    fill_random();
    xm[0] = 16'sd1000; wm[0] = 16'sd700;
    start = 1'b1;
    @(negedge clk); start = 1'b0;   // LOAD_B
    @(negedge clk);                 // CLEAR
    @(negedge clk);                 // MAC, neuron 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    obs = {busy1, busy0, b1.y_valid, b0.y_valid, b1.mac_ctrl, b1.mac_in, b1.mac_w, b0.mac_in, 12'(b1.mac_bias)};
    checks++; if (obs !== '0) begin failures++; $display("FAIL mid-pass reset: got %h exp 0", obs); end
    @(negedge clk);
    run_pass(0, tv, td);
    checks++; if (td != 16) begin failures++; $display("FAIL restart done cycle: got %0d exp 16", td); end
    for (int i = 0; i < N_OUT; i++) begin
      checks++;
      if (got0.size() <= i || got0[i] !== exp_entry(i, 0)) begin
        failures++; $display("FAIL restart out%0d: got %p exp %h", i, got0, exp_entry(i, 0));
      end
    end
  endtask

  task automatic test_start_ignored();
    int tv, td;
    fill_random();
    run_pass(3, tv, td);
    checks++; if (td != 16)  begin failures++; $display("FAIL ignore done cycle: got %0d exp 16", td); end
    checks++; if (ndone != 1) begin failures++; $display("FAIL ignore done pulses: got %0d exp 1", ndone); end
    checks++; if (busy_after != 0) begin failures++; $display("FAIL ignore restarted: busy cycles %0d exp 0", busy_after); end
    checks++;
    if (got1.size() != N_OUT) begin failures++; $display("FAIL ignore output count: got %0d exp %0d", got1.size(), N_OUT); end
  endtask

  task automatic test_back_to_back();
    int tv, td;
    for (int it = 0; it < 6; it++) begin
      fill_random();
      run_pass(1, tv, td);
      checks++; if (td < 16) begin failures++; $display("FAIL random pass %0d done: got %0d exp >=16", it, td); end
      for (int i = 0; i < N_OUT; i++) begin
        checks++;
        if (got1.size() <= i || got1[i] !== exp_entry(i, 1)) begin
          failures++; $display("FAIL random %0d relu out%0d: got %p exp %h", it, i, got1, exp_entry(i, 1));
        end
        checks++;
        if (got0.size() <= i || got0[i] !== exp_entry(i, 0)) begin
          failures++; $display("FAIL random %0d lin out%0d: got %p exp %h", it, i, got0, exp_entry(i, 0));
        end
      end
    end
  endtask

  initial begin
    fill_basic();
    test_reset();
    test_basic();
    test_bias();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: summary not reached, got timeout exp completion");
    $fatal(1);
  end
endmodule
